nabp_sinogram_arbiter: RTL and testbench
========================================

Name: nabp_sinogram_arbiter

Overview:
Round-robin read arbiter that shares the single sinogram RAM read port (sg_addr/sg_val) between NUM_REQ sinogram fetch requesters. It sits between the fetch front-ends inside NABP and the sinogram RAM/LUT. It issues one read per cycle and routes each returned sample back to its originating requester through a latency-matched tag pipeline.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 16, sinogram address width (matches kSinogramAddressLength)
DATA_W, 12, sinogram sample width (matches kDataLength)
RAM_LATENCY, 1, cycles from sg_addr valid to sg_val valid (1..3)

Ports:
clk  in  1  clock
reset_n  in  1  reset
clear  in  1  synchronous flush: drop in-flight reads, reset priority pointer
req  in  NUM_REQ  per-requester read request; held until granted
req_addr  in  NUM_REQ*ADDR_W  packed addresses; slice i belongs to req[i]
gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as the winning req
sg_addr  out  ADDR_W  registered address to sinogram RAM
sg_val  in  DATA_W  RAM read data
rvalid  out  NUM_REQ  one-hot, registered; response valid for requester i
rdata  out  DATA_W  registered read data, broadcast to all requesters
busy  out  1  high while any read is in flight

Behaviour:
- Reset: reset_n is asynchronous and active-high. When it is asserted: sg_addr=0, rvalid=0, rdata=0, busy=0, priority pointer=0, tag pipeline empty. gnt is 0 while reset is asserted.
- Handshake: requester i asserts req[i] and drives a stable req_addr slice. The transfer completes in the cycle gnt[i]=1. The requester may deassert or change its address in the next cycle. The arbiter never grants a requester whose req is low.
- Arbitration: at most one gnt bit per cycle. Search starts at index ptr, ascending with wrap at NUM_REQ-1 -> 0. The first asserted req wins.
- Pointer update: after a grant to index k, ptr <= (k+1) mod NUM_REQ. With no grant, ptr is unchanged.
- Fairness: a continuously asserted req is granted within NUM_REQ cycles.
- Issue timing: grant in cycle t; sg_addr = granted address during t+1.
- With no grant, sg_addr holds its last value. The RAM read is unconditional, and the result is discarded because no tag is valid.
- Return timing: sg_val is sampled RAM_LATENCY cycles after sg_addr becomes valid. rdata/rvalid are valid during cycle t+2+RAM_LATENCY (3 cycles after grant for RAM_LATENCY=1). rvalid is a 1-cycle pulse.
- Tag pipeline: depth RAM_LATENCY+1. Each stage holds a valid bit plus a requester index of width clog2(NUM_REQ). Stage 0 is loaded with the grant, and the pipeline shifts every cycle; it never stalls.
- Ordering: responses return in grant order. Throughput is 1 read per cycle sustained.
- busy: high whenever any tag stage is valid or rvalid is high.
- clear: in a cycle with clear=1, gnt=0, all tag valid bits <= 0, rvalid <= 0, and ptr <= 0. sg_addr and rdata hold their values. clear has priority over req.
- Reset or clear mid-operation: all outstanding reads are lost with no response. Requesters must re-request.
- Simultaneous events: clear and req together -> no grant. Grant to k in the same cycle as rvalid for k is legal; the two are independent.
- NUM_REQ=1 degenerates to a pass-through with gnt = req.

Decomposition:
- Shared package nabp_arbiter_pkg: the tag-index width function clog2(NUM_REQ) and the default widths, tied to kSinogramAddressLength and kDataLength.
- Sub-module nabp_rr_select: a combinational rotating-priority one-hot selector. Inputs are req and ptr; outputs are the one-hot gnt and the encoded winner index.
- Top level: the ptr register, sg_addr register, tag shift pipeline, and rdata/rvalid output registers.

Test Plan:
- Single requester: req[2]=1, req_addr slice 2=0x0123, RAM returns addr+1 -> gnt=0100 at t; sg_addr=0x0123 at t+1; rvalid=0100, rdata=0x0124 at t+3 (RAM_LATENCY=1).
- All four requesting continuously from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001, ...; one rvalid per cycle in the same order, each rdata matching its address.
- Sparse fairness: req[0] and req[3] held high, ptr=1 -> gnt[3] first, then gnt[0], alternating; no requester waits more than 4 cycles.
- clear with 3 reads in flight -> no rvalid pulses afterwards; busy falls the next cycle; the next grant starts from index 0.
- Async reset pulse mid-burst (reset_n=1 between edges) -> all outputs 0 immediately; no stale rvalid after release.
- Back-to-back identical addresses from different requesters -> each receives its own rvalid in grant order with identical rdata.

Source files
------------

// File: rtl/nabp_arbiter_pkg.sv
// Shared constants and helpers for the NABP sinogram read arbiter.
// Default widths follow the sinogram address and sample lengths used across NABP.
package nabp_arbiter_pkg;

    localparam int kSinogramAddressLength = 16;
    localparam int kDataLength            = 12;
    localparam int kDefaultNumReq         = 4;
    localparam int kDefaultRamLatency     = 1;

    // Width of an encoded requester index; never narrower than one bit so a
    // single-requester build still has a legal vector.
    function automatic int tag_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/nabp_rr_select.sv
// Rotating-priority one-hot selector: the first asserted request at or after
// ptr (wrapping at NUM_REQ-1 -> 0) wins. Purely combinational.
module nabp_rr_select
    import nabp_arbiter_pkg::*;
#(
    parameter int NUM_REQ = kDefaultNumReq,
    parameter int IDX_W   = tag_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic found;
    int   pos;

    // Walk the candidates in priority order and latch onto the first requester
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int o = 0; o < NUM_REQ; o++) begin
            pos = int'(ptr) + o;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (pos == i) && req[i]) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/nabp_sinogram_arbiter.sv
// Round-robin arbiter sharing the single sinogram RAM read port between the
// NABP fetch front-ends. One read issues per cycle; a tag pipeline matched to
// the RAM latency steers each returned sample back to its requester.
module nabp_sinogram_arbiter
    import nabp_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = kDefaultNumReq,
    parameter int ADDR_W      = kSinogramAddressLength,
    parameter int DATA_W      = kDataLength,
    parameter int RAM_LATENCY = kDefaultRamLatency
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         sg_addr,
    input  logic [DATA_W-1:0]         sg_val,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy
);

    localparam int IDX_W = tag_width(NUM_REQ);
    localparam int DEPTH = RAM_LATENCY + 1;

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   next_ptr;
    logic [IDX_W-1:0]   sel_idx;
    logic [NUM_REQ-1:0] sel_gnt;
    logic               grant_any;
    logic [ADDR_W-1:0]  grant_addr;
    logic [DEPTH-1:0]   tag_valid;
    logic [IDX_W-1:0]   tag_idx [DEPTH];

    nabp_rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_select (
        .req (req),
        .ptr (ptr),
        .gnt (sel_gnt),
        .idx (sel_idx)
    );

    // Suppress the grant while reset is held or a flush is requested
    always_comb begin
        gnt = sel_gnt;
        if (reset_n || clear) begin
            gnt = '0;
        end
    end

    assign grant_any = |gnt;

    // Pick out the address slice belonging to the selected requester
    always_comb begin
        grant_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_gnt[i]) begin
                grant_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Priority moves to the requester just after the winner, wrapping at the top
    always_comb begin
        if (sel_idx == IDX_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = sel_idx + 1'b1;
        end
    end

    // Pointer, RAM address, tag shift pipeline and response output registers
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            ptr       <= '0;
            sg_addr   <= '0;
            tag_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                tag_idx[k] <= '0;
            end
            rvalid    <= '0;
            rdata     <= '0;
        end else begin
            if (grant_any) begin
                sg_addr <= grant_addr;
            end
            tag_idx[0] <= sel_idx;
            for (int k = 1; k < DEPTH; k++) begin
                tag_idx[k] <= tag_idx[k-1];
            end
            if (clear) begin
                ptr       <= '0;
                tag_valid <= '0;
                rvalid    <= '0;
            end else begin
                if (grant_any) begin
                    ptr <= next_ptr;
                end
                tag_valid <= {tag_valid[DEPTH-2:0], grant_any};
                for (int i = 0; i < NUM_REQ; i++) begin
                    rvalid[i] <= tag_valid[DEPTH-1] && (tag_idx[DEPTH-1] == IDX_W'(i));
                end
                if (tag_valid[DEPTH-1]) begin
                    rdata <= sg_val;
                end
            end
        end
    end

    assign busy = (|tag_valid) | (|rvalid);

endmodule

// File: tb/tb_nabp_sinogram_arbiter.sv
// Randomized self-checking bench for nabp_sinogram_arbiter. A behavioural
// model tracks requesters, round-robin priority and a queue of expected
// responses tagged with the cycle they are due.
module tb_nabp_sinogram_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 12;
    localparam int RAM_LATENCY = 1;
    localparam int RESP_DELAY  = 2 + RAM_LATENCY;

    logic                      clk      = 1'b0;
    logic                      reset_n  = 1'b1;
    logic                      clear    = 1'b0;
    logic [NUM_REQ-1:0]        req      = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         sg_addr;
    logic [DATA_W-1:0]         sg_val   = '0;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;

    nabp_sinogram_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .RAM_LATENCY (RAM_LATENCY)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .sg_addr  (sg_addr),
        .sg_val   (sg_val),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Sinogram RAM stand-in: one-cycle read returning address + 1
    always @(posedge clk) begin
        sg_val <= DATA_W'(sg_addr + 16'd1);
    end

    typedef struct {
        int                due;
        int                idx;
        logic [DATA_W-1:0] data;
    } resp_t;

    resp_t             pend[$];
    int                m_ptr;
    logic [ADDR_W-1:0] m_addr;
    bit                active [NUM_REQ];
    logic [ADDR_W-1:0] addr_r [NUM_REQ];
    int                waited [NUM_REQ];
    int                cycle;
    int                checks;
    int                failures;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cycle, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int prob, input int clear_prob, input bit same_addr,
                                 input logic [NUM_REQ-1:0] mask);
        int                 winner;
        int                 cand;
        bit                 do_clear;
        logic [NUM_REQ-1:0] exp_gnt;
        logic [NUM_REQ-1:0] exp_rvalid;
        resp_t              r;

        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!active[i] && mask[i] && ($urandom_range(0, 99) < prob)) begin
                active[i] = 1'b1;
                addr_r[i] = same_addr ? 16'h0ABC : ADDR_W'($urandom);
                waited[i] = 0;
            end
        end
        do_clear = ($urandom_range(0, 99) < clear_prob);
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = active[i];
            req_addr[i*ADDR_W +: ADDR_W] = addr_r[i];
        end
        clear = do_clear;
        #1;

        winner = -1;
        if (!do_clear) begin
            for (int o = 0; o < NUM_REQ; o++) begin
                cand = (m_ptr + o) % NUM_REQ;
                if (winner < 0 && active[cand]) begin
                    winner = cand;
                end
            end
        end
        exp_gnt = (winner >= 0) ? NUM_REQ'(1 << winner) : '0;
        checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
        checkOutput("sg_addr", 32'(sg_addr), 32'(m_addr));
        checkOutput("busy", 32'(busy), 32'(pend.size() != 0));

        exp_rvalid = '0;
        if (pend.size() > 0 && pend[0].due == cycle) begin
            exp_rvalid[pend[0].idx] = 1'b1;
            checkOutput("rdata", 32'(rdata), 32'(pend[0].data));
            void'(pend.pop_front());
        end
        checkOutput("rvalid", 32'(rvalid), 32'(exp_rvalid));

        if (do_clear) begin
            pend.delete();
            m_ptr = 0;
            for (int i = 0; i < NUM_REQ; i++) waited[i] = 0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (active[i] && i != winner) waited[i]++;
            end
            if (winner >= 0) begin
                checkOutput("fair_wait", 32'(waited[winner] < NUM_REQ), 32'd1);
                r.due  = cycle + RESP_DELAY;
                r.idx  = winner;
                r.data = DATA_W'(addr_r[winner] + 16'd1);
                pend.push_back(r);
                m_addr         = addr_r[winner];
                m_ptr          = (winner + 1) % NUM_REQ;
                active[winner] = 1'b0;
            end
        end
        cycle++;
    endtask

    task automatic doReset(input int hold);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rst_rdata", 32'(rdata), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_sg_addr", 32'(sg_addr), 32'd0);
        req   = '0;
        clear = 1'b0;
        repeat (hold) @(negedge clk);
        reset_n = 1'b0;
        pend.delete();
        m_ptr  = 0;
        m_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) waited[i] = 0;
        cycle += hold + 2;
    endtask

    // Hard time limit so a wedged run still reports
    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        checks   = 0;
        failures = 0;
        cycle    = 0;
        m_ptr    = 0;
        m_addr   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            active[i] = 1'b0;
            addr_r[i] = '0;
            waited[i] = 0;
        end

        $display("[TB] power-on reset");
        doReset(2);

        $display("[TB] single requester 2 at 0x0123");
        active[2] = 1'b1;
        addr_r[2] = 16'h0123;
        repeat (6) applyStimulus(0, 0, 1'b0, '0);

        $display("[TB] all requesters continuous");
        repeat (40) applyStimulus(100, 0, 1'b0, '1);

        $display("[TB] sparse requesters 0 and 3");
        repeat (24) applyStimulus(100, 0, 1'b0, 4'b1001);

        $display("[TB] clear with reads in flight");
        repeat (6) applyStimulus(100, 0, 1'b0, '1);
        applyStimulus(100, 100, 1'b0, '1);
        repeat (8) applyStimulus(0, 0, 1'b0, '0);

        $display("[TB] random traffic with occasional clear");
        repeat (300) applyStimulus(40, 8, 1'b0, '1);

        $display("[TB] identical addresses from different requesters");
        repeat (60) applyStimulus(70, 0, 1'b1, '1);

        $display("[TB] async reset mid-burst");
        repeat (10) applyStimulus(100, 0, 1'b0, '1);
        doReset(3);
        repeat (50) applyStimulus(60, 0, 1'b0, '1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
